cdb_arbiter: RTL

Common Data Bus arbiter and broadcaster for the out-of-order OTTER. It collects completed results from the functional units and buffers each in a small per-unit FIFO. One result per cycle is chosen round-robin and driven as a registered tag/value broadcast. Reservation stations, the map table and the register file consume that broadcast. It also returns a per-unit completion pulse so each unit can release its reservation station.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_src_fifo.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the out-of-order OTTER datapath.
// Tag type, invalid marker and the bundled CDB view for consumers.
package cpu_types;

  typedef logic [4:0] RS_tag_type;

  localparam RS_tag_type INVALID = 5'h1F;

  typedef struct packed {
    logic       valid;
    RS_tag_type tag;
    logic [31:0] val;
  } cdb_t;

  // base + off folded back into [0, n) for off < n
  function automatic int rr_idx(int base, int off, int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO feeding the CDB arbiter.
// Holds {tag, value} pairs in push order; push and pop may coincide.
module cdb_src_fifo
  import cpu_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       i_push,
  input  RS_tag_type                 i_tag,
  input  logic [31:0]                i_val,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output RS_tag_type                 o_tag,
  output logic [31:0]                o_val
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  RS_tag_type    r_tag [DEPTH];
  logic [31:0]   r_val [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_tag   = r_tag[r_rptr];
  assign o_val   = r_val[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage needs no reset: the count gates every read
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_tag[r_wptr] <= i_tag;
      r_val[r_wptr] <= i_val;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: buffers FU results per source and
// broadcasts one per cycle, round-robin, through an output register.
module cdb_arbiter
  import cpu_types::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_SRC-1:0]          FU_VALID,
  input  RS_tag_type [NUM_SRC-1:0]    FU_TAG,
  input  logic [NUM_SRC-1:0][31:0]    FU_VAL,
  output logic [NUM_SRC-1:0]          FU_READY,
  output logic                        CDB_VALID,
  output RS_tag_type                  CDB_tag,
  output logic [31:0]                 CDB_val,
  output logic [NUM_SRC-1:0]          FU_DONE
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [CW-1:0]      w_count    [NUM_SRC];
  RS_tag_type         w_head_tag [NUM_SRC];
  logic [31:0]        w_head_val [NUM_SRC];

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_grant;
  logic [PW-1:0] w_rr_next;
  logic          w_gnt_vld;

  logic               r_cdb_valid;
  RS_tag_type         r_cdb_tag;
  logic [31:0]        r_cdb_val;
  logic [NUM_SRC-1:0] r_fu_done;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // ready looks only at the registered count, never at a same-cycle pop
    assign FU_READY[g] = (w_count[g] < CW'(DEPTH)) && !RST;
    assign w_push[g]   = FU_VALID[g] && !w_full[g] && !RST;

    cdb_src_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (w_push[g]),
      .i_tag   (FU_TAG[g]),
      .i_val   (FU_VAL[g]),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g]),
      .o_tag   (w_head_tag[g]),
      .o_val   (w_head_val[g])
    );
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_grant   = r_rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_gnt_vld &&
          !w_empty[rr_idx(int'(r_rr_ptr), k, NUM_SRC)]) begin
        w_gnt_vld = 1'b1;
        w_grant   = PW'(rr_idx(int'(r_rr_ptr), k, NUM_SRC));
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_gnt_vld)
      w_pop[w_grant] = 1'b1;
  end

  assign w_rr_next = PW'(rr_idx(int'(w_grant), 1, NUM_SRC));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= INVALID;
      r_cdb_val   <= '0;
      r_fu_done   <= '0;
    end else begin
      r_cdb_valid <= w_gnt_vld;
      r_fu_done   <= w_pop;
      if (w_gnt_vld) begin
        r_rr_ptr  <= w_rr_next;
        r_cdb_tag <= w_head_tag[w_grant];
        r_cdb_val <= w_head_val[w_grant];
      end else begin
        r_cdb_tag <= INVALID;
        r_cdb_val <= '0;
      end
    end
  end

  assign CDB_VALID = r_cdb_valid;
  assign CDB_tag   = r_cdb_tag;
  assign CDB_val   = r_cdb_val;
  assign FU_DONE   = r_fu_done;

endmodule
